req_rsp_arbiter: RTL and testbench
==================================

REQ_RSP_ARBITER -- requirements
Module: req_rsp_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the request and response data width.
REQ-003 Parameter DEPTH, default 4, SHALL set the maximum outstanding requests, which is the tag FIFO depth (power of 2).
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 in_req_ready  output  NUM_REQ  per-requester request accept.
REQ-008 in_req_data  input  NUM_REQ*DATA_WIDTH  requester i data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 out_req_valid / out_req_ready / out_req_data  output / input / output  1 / 1 / DATA_WIDTH  shared request channel to the resource.
REQ-010 out_rsp_valid / out_rsp_ready / out_rsp_data  input / output / input  1 / 1 / DATA_WIDTH  shared response channel from the resource.
REQ-011 in_rsp_valid  output  NUM_REQ  per-requester response valid.
REQ-012 in_rsp_ready  input  NUM_REQ  per-requester response accept.
REQ-013 in_rsp_data  output  DATA_WIDTH  response data, broadcast to all requesters.
REQ-014 outstanding  output  $clog2(DEPTH+1)  count of accepted requests not yet answered.
REQ-015 rsp_err  output  1  sticky flag: a response arrived with no outstanding tag.

Function
REQ-016 The FSM SHALL have two states: IDLE and ISSUE.
REQ-017 In IDLE with FIFO not full and any in_req_valid set, the grant SHALL go to the first valid requester, searching round-robin from last_grant+1 (mod NUM_REQ).
REQ-018 in_req_ready[g] SHALL be combinationally 1 only for the granted requester in IDLE with FIFO not full; all other bits SHALL be 0.
REQ-019 On capture: register in_req_data slice g into out_req_data; push tag g into FIFO; set last_grant=g; enter ISSUE.
REQ-020 In ISSUE, out_req_valid SHALL be 1 with out_req_data stable until out_req_ready=1; the block then returns to IDLE.
REQ-021 Latency: request accept to out_req_valid SHALL be 1 cycle.
REQ-022 Peak throughput SHALL be one request per 2 cycles.
REQ-023 in_req_ready SHALL be all-zero in ISSUE.
REQ-024 Response routing:
- head = FIFO head tag.
- When FIFO is not empty: in_rsp_valid[head] = out_rsp_valid; in_rsp_data = out_rsp_data; out_rsp_ready = in_rsp_ready[head].
- Non-head bits of in_rsp_valid SHALL be 0.
REQ-025 The FIFO SHALL pop on out_rsp_valid && out_rsp_ready.
REQ-026 Responses SHALL be returned in issue order; there is no reordering.
REQ-027 FIFO full SHALL block capture even if a pop occurs in the same cycle (no same-cycle push-on-pop when full).
REQ-028 When not full, a simultaneous push and pop SHALL leave outstanding unchanged.
REQ-029 FIFO empty with out_rsp_valid=1: out_rsp_ready=0, in_rsp_valid all 0, and rsp_err set to 1 on the next edge.
REQ-030 outstanding SHALL equal the FIFO occupancy, range 0..DEPTH; read/write pointers SHALL wrap modulo DEPTH.
REQ-031 A requester SHALL NOT be granted twice in a row while another requester is valid.

Reset
REQ-032 While reset=1 at a posedge: state=IDLE, last_grant=NUM_REQ-1, FIFO emptied (outstanding=0), out_req_valid=0, out_req_data=0, rsp_err=0.
REQ-033 During reset: in_req_ready, in_rsp_valid and out_rsp_ready SHALL be 0.
REQ-034 Reset asserted mid-ISSUE or with outstanding>0 SHALL discard the pending request and all tags; there is no replay.

Verification
REQ-035 All 4 requesters valid from reset release, out_req_ready=1 -> grants in order 0,1,2,3,0, one every 2 cycles; out_req_data matches each requester's data.
REQ-036 out_req_ready held 0 for 5 cycles in ISSUE -> out_req_valid=1 and out_req_data stable for all 5 cycles; in_req_ready=0 throughout.
REQ-037 4 requests issued with no responses -> outstanding=4; 5th requester's in_req_ready stays 0; first response pops and returns outstanding to 3; capture resumes next IDLE cycle.
REQ-038 Loopback (rsp=req data) with requesters 2,0,3 issued -> responses appear on in_rsp_valid[2], [0], [3] in that order with matching data; in_rsp_ready[0]=0 for 3 cycles stalls out_rsp_ready.
REQ-039 out_rsp_valid=1 with outstanding=0 -> out_rsp_ready=0, rsp_err=1 next cycle and stays 1 until reset.
REQ-040 reset pulsed in ISSUE with outstanding=2 -> next cycle out_req_valid=0, outstanding=0, and next grant goes to requester 0.

Source files
------------

// File: rtl/req_rsp_arbiter.sv
// req_rsp_arbiter
// Round-robin arbiter that funnels NUM_REQ request ports onto one shared
// request channel and routes in-order responses back using a tag FIFO.
//
// Ports
//   clock, reset                 sole clock, synchronous active-high reset
//   in_req_valid/ready/data      per-requester request handshake, data packed
//                                as slice i -> [i*DATA_WIDTH +: DATA_WIDTH]
//   out_req_valid/ready/data     shared request channel to the resource
//   out_rsp_valid/ready/data     shared response channel from the resource
//   in_rsp_valid/ready           per-requester response handshake
//   in_rsp_data                  response data, broadcast to all requesters
//   outstanding                  tag FIFO occupancy (accepted, not answered)
//   rsp_err                      sticky: response seen with no tag outstanding
module req_rsp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_req_valid,
    output logic [NUM_REQ-1:0]            in_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_req_data,
    output logic                          out_req_valid,
    input  logic                          out_req_ready,
    output logic [DATA_WIDTH-1:0]         out_req_data,
    input  logic                          out_rsp_valid,
    output logic                          out_rsp_ready,
    input  logic [DATA_WIDTH-1:0]         out_rsp_data,
    output logic [NUM_REQ-1:0]            in_rsp_valid,
    input  logic [NUM_REQ-1:0]            in_rsp_ready,
    output logic [DATA_WIDTH-1:0]         in_rsp_data,
    output logic [$clog2(DEPTH+1)-1:0]    outstanding,
    output logic                          rsp_err
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = GW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]            r_state;
    logic [GW-1:0]         r_last_grant;
    logic [DATA_WIDTH-1:0] r_out_req_data;
    logic [GW-1:0]         r_tag_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_rsp_err;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_any_valid;
    logic [GW-1:0]         w_grant;
    logic [SW-1:0]         w_sum;
    logic                  w_capture;
    logic                  w_pop;
    logic                  w_rsp_route;
    logic [GW-1:0]         w_head;
    logic [DATA_WIDTH-1:0] w_sel_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag_mem[r_rd_ptr];

    // Round-robin search from last_grant+1. Scanning from the farthest offset
    // down to the nearest lets the nearest valid requester win.
    always_comb begin
        w_grant     = r_last_grant;
        w_any_valid = 1'b0;
        w_sum       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_sum = {1'b0, r_last_grant} + SW'(off);
            if (w_sum >= SW'(NUM_REQ)) begin
                w_sum = w_sum - SW'(NUM_REQ);
            end
            if (in_req_valid[w_sum[GW-1:0]]) begin
                w_grant     = w_sum[GW-1:0];
                w_any_valid = 1'b1;
            end
        end
    end

    // Full blocks capture even if a pop lands in the same cycle.
    assign w_capture   = !reset && (r_state == ST_IDLE) && !w_full && w_any_valid;
    assign w_rsp_route = !reset && !w_empty;
    assign w_pop       = out_rsp_valid && out_rsp_ready;

    always_comb begin
        in_req_ready = '0;
        in_rsp_valid = '0;
        w_sel_data   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_req_ready[i] = w_capture && (w_grant == GW'(i));
            in_rsp_valid[i] = w_rsp_route && out_rsp_valid && (w_head == GW'(i));
            if (w_grant == GW'(i)) begin
                w_sel_data = in_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_rsp_ready = w_rsp_route && in_rsp_ready[w_head];
    assign in_rsp_data   = out_rsp_data;
    assign out_req_valid = (r_state == ST_ISSUE);
    assign out_req_data  = r_out_req_data;
    assign outstanding   = r_count;
    assign rsp_err       = r_rsp_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_last_grant   <= GW'(NUM_REQ - 1);
            r_out_req_data <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rsp_err      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_capture) begin
                    r_state        <= ST_ISSUE;
                    r_out_req_data <= w_sel_data;
                    r_last_grant   <= w_grant;
                end
            end else if (out_req_ready) begin
                r_state <= ST_IDLE;
            end

            if (w_capture) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end

            if (w_capture && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_capture && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (out_rsp_valid && w_empty) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read while occupied.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

endmodule

// File: tb/tb_req_rsp_arbiter.sv
// tb_req_rsp_arbiter
// Self-checking bench for req_rsp_arbiter (NUM_REQ=4, DATA_WIDTH=32, DEPTH=4).
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
// Issued request data is checked by a negedge monitor against a queue of
// expected words pushed as each request is driven.
module tb_req_rsp_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DP = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [NR-1:0]      in_req_valid;
    logic [NR-1:0]      in_req_ready;
    logic [NR*DW-1:0]   in_req_data;
    logic               out_req_valid;
    logic               out_req_ready;
    logic [DW-1:0]      out_req_data;
    logic               out_rsp_valid;
    logic               out_rsp_ready;
    logic [DW-1:0]      out_rsp_data;
    logic [NR-1:0]      in_rsp_valid;
    logic [NR-1:0]      in_rsp_ready;
    logic [DW-1:0]      in_rsp_data;
    logic [2:0]         outstanding;
    logic               rsp_err;

    req_rsp_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .DEPTH      (DP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_req_valid  (in_req_valid),
        .in_req_ready  (in_req_ready),
        .in_req_data   (in_req_data),
        .out_req_valid (out_req_valid),
        .out_req_ready (out_req_ready),
        .out_req_data  (out_req_data),
        .out_rsp_valid (out_rsp_valid),
        .out_rsp_ready (out_rsp_ready),
        .out_rsp_data  (out_rsp_data),
        .in_rsp_valid  (in_rsp_valid),
        .in_rsp_ready  (in_rsp_ready),
        .in_rsp_data   (in_rsp_data),
        .outstanding   (outstanding),
        .rsp_err       (rsp_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    logic [31:0] req_q[$];

    typedef struct {
        logic [3:0] valid;
        logic [3:0] exp_ready;
        int         exp_grant;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] dv(input int tag, input int i);
        return 32'h5A00_0000 | 32'(tag << 8) | 32'(i << 4) | 32'(i);
    endfunction

    function automatic logic [3:0] oh(input int i);
        return 4'(1 << i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int tag);
        for (int i = 0; i < NR; i++) begin
            in_req_data[i*DW +: DW] = dv(tag, i);
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        in_req_valid  = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        in_rsp_ready  = '0;
        out_rsp_data  = '0;
        req_q.delete();
        tick();
        // Hostile inputs while held in reset must not leak through.
        in_req_valid  = '1;
        out_rsp_valid = 1'b1;
        in_rsp_ready  = '1;
        settle();
        chk("rst_in_req_ready", in_req_ready, 0);
        chk("rst_in_rsp_valid", in_rsp_valid, 0);
        chk("rst_out_rsp_ready", out_rsp_ready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_out_req_valid", out_req_valid, 0);
        chk("rst_out_req_data", out_req_data, 0);
        tick();
        in_req_valid  = '0;
        out_rsp_valid = 1'b0;
        in_rsp_ready  = '0;
        chk("rst_rsp_err", rsp_err, 0);
        reset = 1'b0;
    endtask

    // Request-channel scoreboard.
    always @(negedge clock) begin
        if (!reset && out_req_valid && out_req_ready) begin
            if (req_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL req_sb: issued %h but none expected", out_req_data);
            end else begin
                chk("req_sb", out_req_data, req_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order1[5];
        int order3[4];
        in_req_data = '0;
        tbl[0] = '{4'b1111, 4'b0001, 0};
        tbl[1] = '{4'b1111, 4'b0010, 1};
        tbl[2] = '{4'b0001, 4'b0001, 0};
        tbl[3] = '{4'b1001, 4'b1000, 3};
        tbl[4] = '{4'b0110, 4'b0010, 1};
        tbl[5] = '{4'b0000, 4'b0000, -1};
        tbl[6] = '{4'b0101, 4'b0100, 2};
        tbl[7] = '{4'b0100, 4'b0100, 2};
        tbl[8] = '{4'b1010, 4'b1000, 3};
        tbl[9] = '{4'b0011, 4'b0001, 0};
        order1 = '{0, 1, 2, 3, 0};
        order3 = '{3, 0, 1, 2};

        do_reset();

        // Round-robin table: grant, issue, single response per vector.
        for (int s = 0; s < 10; s++) begin
            set_data(16 + s);
            in_req_valid  = tbl[s].valid;
            out_req_ready = 1'b1;
            settle();
            chk("tbl_ready", in_req_ready, tbl[s].exp_ready);
            if (tbl[s].exp_grant >= 0) begin
                req_q.push_back(dv(16 + s, tbl[s].exp_grant));
                tick();
                in_req_valid = '0;
                settle();
                chk("tbl_issue_valid", out_req_valid, 1);
                tick();
                out_rsp_valid = 1'b1;
                out_rsp_data  = dv(112 + s, 0);
                in_rsp_ready  = '1;
                settle();
                chk("tbl_rsp_route", in_rsp_valid, tbl[s].exp_ready);
                chk("tbl_rsp_data", in_rsp_data, dv(112 + s, 0));
                tick();
                out_rsp_valid = 1'b0;
            end else begin
                tick();
                in_req_valid = '0;
                settle();
                chk("tbl_no_issue", out_req_valid, 0);
            end
        end

        // All four valid from reset release: grants 0,1,2,3,0 every 2 cycles.
        do_reset();
        set_data(53);
        in_req_valid  = 4'hF;
        out_req_ready = 1'b1;
        in_rsp_ready  = 4'hF;
        for (int k = 0; k < 5; k++) req_q.push_back(dv(53, order1[k]));
        for (int k = 0; k < 10; k++) begin
            out_rsp_valid = (k % 2 == 1);
            settle();
            if (k % 2 == 0) begin
                chk("rr_ready", in_req_ready, oh(order1[k/2]));
                chk("rr_outst_idle", outstanding, 0);
            end else begin
                chk("rr_issue_ready", in_req_ready, 0);
                chk("rr_rsp_route", in_rsp_valid, oh(order1[k/2]));
                chk("rr_outst_issue", outstanding, 1);
            end
            tick();
        end
        in_req_valid  = '0;
        out_rsp_valid = 1'b0;

        // ISSUE held for 5 cycles with out_req_ready low.
        set_data(54);
        in_req_valid  = 4'b0100;
        out_req_ready = 1'b0;
        settle();
        chk("hold_grant", in_req_ready, 4'b0100);
        req_q.push_back(dv(54, 2));
        tick();
        in_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            set_data(96 + k);
            settle();
            chk("hold_valid", out_req_valid, 1);
            chk("hold_data", out_req_data, dv(54, 2));
            chk("hold_ready", in_req_ready, 0);
            tick();
        end
        out_req_ready = 1'b1;
        tick();
        in_req_valid  = '0;
        out_rsp_valid = 1'b1;
        settle();
        chk("hold_rsp_route", in_rsp_valid, 4'b0100);
        chk("hold_outst", outstanding, 1);
        tick();
        out_rsp_valid = 1'b0;
        settle();
        chk("hold_drained", outstanding, 0);

        // Fill the tag FIFO with no responses, then free one slot.
        set_data(55);
        in_req_valid = 4'hF;
        for (int k = 0; k < 4; k++) req_q.push_back(dv(55, order3[k]));
        for (int k = 0; k < 8; k++) begin
            settle();
            if (k % 2 == 0) chk("fill_ready", in_req_ready, oh(order3[k/2]));
            else            chk("fill_issue_ready", in_req_ready, 0);
            tick();
        end
        settle();
        chk("full_outst", outstanding, 4);
        chk("full_ready", in_req_ready, 0);
        tick();
        chk("full_ready_again", in_req_ready, 0);
        out_rsp_valid = 1'b1;
        settle();
        chk("full_head_route", in_rsp_valid, 4'b1000);
        chk("full_pop_blocks", in_req_ready, 0);
        tick();
        out_rsp_valid = 1'b0;
        settle();
        chk("full_after_pop", outstanding, 3);
        chk("full_resume", in_req_ready, 4'b1000);
        req_q.push_back(dv(55, 3));
        tick();
        in_req_valid = '0;
        settle();
        chk("full_refill", outstanding, 4);
        tick();
        for (int k = 0; k < 4; k++) begin
            out_rsp_valid = 1'b1;
            settle();
            chk("full_drain_route", in_rsp_valid, oh((k + 0) % 4));
            tick();
        end
        out_rsp_valid = 1'b0;
        settle();
        chk("full_drained", outstanding, 0);

        // Loopback: requesters 2,0,3 issued, responses come back in that order.
        set_data(56);
        in_req_valid = 4'b0100;
        settle();
        chk("lb_grant2", in_req_ready, 4'b0100);
        req_q.push_back(dv(56, 2));
        tick();
        in_req_valid = '0;
        tick();
        in_req_valid = 4'b0001;
        settle();
        chk("lb_grant0", in_req_ready, 4'b0001);
        req_q.push_back(dv(56, 0));
        tick();
        in_req_valid = '0;
        tick();
        in_req_valid = 4'b1000;
        settle();
        chk("lb_grant3", in_req_ready, 4'b1000);
        req_q.push_back(dv(56, 3));
        tick();
        in_req_valid = '0;
        tick();
        out_rsp_valid = 1'b1;
        out_rsp_data  = dv(56, 2);
        settle();
        chk("lb_rsp2_route", in_rsp_valid, 4'b0100);
        chk("lb_rsp2_data", in_rsp_data, dv(56, 2));
        chk("lb_rsp2_ready", out_rsp_ready, 1);
        tick();
        out_rsp_data = dv(56, 0);
        in_rsp_ready = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("lb_stall_route", in_rsp_valid, 4'b0001);
            chk("lb_stall_ready", out_rsp_ready, 0);
            chk("lb_stall_outst", outstanding, 2);
            tick();
        end
        in_rsp_ready = 4'hF;
        settle();
        chk("lb_rsp0_ready", out_rsp_ready, 1);
        chk("lb_rsp0_data", in_rsp_data, dv(56, 0));
        tick();
        out_rsp_data = dv(56, 3);
        settle();
        chk("lb_rsp3_route", in_rsp_valid, 4'b1000);
        tick();
        out_rsp_valid = 1'b0;
        settle();
        chk("lb_drained", outstanding, 0);

        // Push and pop in the same cycle while not full.
        set_data(57);
        in_req_valid = 4'b0001;
        settle();
        chk("pp_grant0", in_req_ready, 4'b0001);
        req_q.push_back(dv(57, 0));
        tick();
        in_req_valid = '0;
        tick();
        in_req_valid  = 4'b0010;
        out_rsp_valid = 1'b1;
        settle();
        chk("pp_grant1", in_req_ready, 4'b0010);
        chk("pp_route0", in_rsp_valid, 4'b0001);
        req_q.push_back(dv(57, 1));
        tick();
        in_req_valid  = '0;
        out_rsp_valid = 1'b0;
        settle();
        chk("pp_outst", outstanding, 1);
        tick();
        out_rsp_valid = 1'b1;
        settle();
        chk("pp_route1", in_rsp_valid, 4'b0010);
        tick();
        out_rsp_valid = 1'b0;
        settle();
        chk("pp_drained", outstanding, 0);

        // Stray response with nothing outstanding sets a sticky error.
        out_rsp_valid = 1'b1;
        settle();
        chk("err_rsp_ready", out_rsp_ready, 0);
        chk("err_rsp_route", in_rsp_valid, 0);
        chk("err_before_edge", rsp_err, 0);
        tick();
        out_rsp_valid = 1'b0;
        settle();
        chk("err_set", rsp_err, 1);
        tick();
        tick();
        tick();
        chk("err_sticky", rsp_err, 1);

        // Reset in ISSUE with two outstanding discards everything.
        do_reset();
        set_data(64);
        out_req_ready = 1'b1;
        in_req_valid  = 4'b0001;
        req_q.push_back(dv(64, 0));
        tick();
        in_req_valid = '0;
        tick();
        in_req_valid  = 4'b0010;
        out_req_ready = 1'b0;
        tick();
        in_req_valid = '0;
        settle();
        chk("mid_outst", outstanding, 2);
        chk("mid_issue", out_req_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("mid_rst_valid", out_req_valid, 0);
        chk("mid_rst_outst", outstanding, 0);
        in_req_valid = 4'hF;
        settle();
        chk("mid_rst_grant", in_req_ready, 4'b0001);
        req_q.push_back(dv(64, 0));
        out_req_ready = 1'b1;
        tick();
        in_req_valid = '0;
        tick();
        chk("sb_empty", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
